// File: rtl/cache_define.sv
// cache_define: shared MESI, bus-op, snoop-result and L1-message types plus line geometry helpers.
package cache_define;
  localparam int OFFSET_W = 6;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;
  typedef enum logic [2:0] {OP_NONE = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INVALIDATE = 3'd3, OP_RWIM = 3'd4} bus_op_t;
  typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2} snoop_result_t;
  typedef enum logic [2:0] {L1_NONE = 3'd0, L1_GETLINE = 3'd1, L1_SENDLINE = 3'd2, L1_INVALIDATELINE = 3'd3, L1_EVICTLINE = 3'd4} l1_msg_t;
  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets) - OFFSET_W;
  endfunction
endpackage

// File: rtl/llc_snoop_way_match.sv
// llc_snoop_way_match: combinational tag compare across all valid ways; lowest matching way wins.
module llc_snoop_way_match import cache_define::*; #(
  parameter int WAYS = 8,
  parameter int TAG_W = 20,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [WAYS*TAG_W-1:0] way_tag_i,
  input  logic [WAYS*2-1:0]     way_mesi_i,
  output logic                  hit_o,
  output logic [WAY_W-1:0]      hit_way_o,
  output logic [1:0]            hit_mesi_o,
  output logic                  multi_hit_o
);
  always_comb begin
    hit_o = 1'b0;
    hit_way_o = '0;
    hit_mesi_o = MESI_I;
    multi_hit_o = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_mesi_i[w*2 +: 2] != MESI_I && way_tag_i[w*TAG_W +: TAG_W] == tag_i) begin
        if (hit_o) multi_hit_o = 1'b1;
        else begin
          hit_o = 1'b1;
          hit_way_o = WAY_W'(w);
          hit_mesi_o = way_mesi_i[w*2 +: 2];
        end
      end
    end
  end
endmodule

// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: answers bus snoops from the LLC tag/MESI array, applies the MESI
// transition and pulls dirty lines from L1 for writeback when a Modified line is hit.
module llc_snoop_responder import cache_define::*; #(
  parameter int SETS = 64,
  parameter int WAYS = 8,
  parameter int ADDR_W = 32,
  localparam int INDEX_W = index_w(SETS),
  localparam int TAG_W = tag_w(ADDR_W, SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [2:0]            snp_op,
  input  logic [ADDR_W-1:0]     snp_addr,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_result,
  output logic                  ta_rd_en,
  output logic [INDEX_W-1:0]    ta_rd_index,
  input  logic [WAYS*TAG_W-1:0] ta_rd_tag,
  input  logic [WAYS*2-1:0]     ta_rd_mesi,
  output logic                  ta_wr_en,
  output logic [INDEX_W-1:0]    ta_wr_index,
  output logic [WAY_W-1:0]      ta_wr_way,
  output logic [1:0]            ta_wr_mesi,
  output logic                  l1_msg_valid,
  output logic [2:0]            l1_msg,
  output logic [ADDR_W-1:0]     l1_msg_addr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, GETL1, WB, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] addr_q, line;
  logic [WAY_W-1:0] way_q, m_way;
  mesi_t mesi_q, nxt;
  logic multi_q, m_hit, m_multi, bad;
  logic [1:0] m_mesi;
  logic [INDEX_W-1:0] idx;
  snoop_result_t res;
  l1_msg_t msg;
  assign idx = addr_q[OFFSET_W +: INDEX_W];
  assign line = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  llc_snoop_way_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_match (
    .tag_i(addr_q[ADDR_W-1 -: TAG_W]),
    .way_tag_i(ta_rd_tag),
    .way_mesi_i(ta_rd_mesi),
    .hit_o(m_hit),
    .hit_way_o(m_way),
    .hit_mesi_o(m_mesi),
    .multi_hit_o(m_multi)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      way_q <= '0;
      mesi_q <= MESI_I;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (snp_valid && snp_ready) begin
        op_q <= snp_op;
        addr_q <= snp_addr;
      end
      if (state_q == COMPARE) begin
        way_q <= m_way;
        mesi_q <= mesi_t'(m_mesi);
        multi_q <= m_multi;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = snp_valid ? LOOKUP : IDLE;
      LOOKUP:  state_d = COMPARE;
      COMPARE: state_d = (m_hit && m_mesi == MESI_M && (op_q == OP_READ || op_q == OP_RWIM)) ? GETL1 : RESP;
      GETL1:   state_d = WB;
      WB:      state_d = wb_ready ? RESP : WB;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // mesi_q is I on a miss, so every row below covers the miss case too
  always_comb begin
    res = SNP_NOHIT;
    nxt = mesi_q;
    msg = L1_NONE;
    bad = 1'b0;
    case (op_q)
      OP_READ: begin
        res = mesi_q == MESI_M ? SNP_HITM : mesi_q == MESI_I ? SNP_NOHIT : SNP_HIT;
        nxt = mesi_q == MESI_I ? MESI_I : MESI_S;
      end
      OP_RWIM: begin
        res = mesi_q == MESI_M ? SNP_HITM : mesi_q == MESI_I ? SNP_NOHIT : SNP_HIT;
        nxt = MESI_I;
        msg = mesi_q == MESI_M ? L1_EVICTLINE : mesi_q == MESI_I ? L1_NONE : L1_INVALIDATELINE;
      end
      OP_INVALIDATE: begin
        res = mesi_q == MESI_S ? SNP_HIT : SNP_NOHIT;
        nxt = mesi_q == MESI_S ? MESI_I : mesi_q;
        msg = mesi_q == MESI_S ? L1_INVALIDATELINE : L1_NONE;
        bad = mesi_q == MESI_E || mesi_q == MESI_M;
      end
      OP_WRITE: bad = mesi_q != MESI_I;
      default:  bad = 1'b1;
    endcase
  end
  assign snp_ready = state_q == IDLE && !rst;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = rsp_valid ? res : SNP_NOHIT;
  assign err = rsp_valid && (bad || multi_q);
  assign ta_rd_en = state_q == LOOKUP;
  assign ta_rd_index = ta_rd_en ? idx : '0;
  assign ta_wr_en = rsp_valid && nxt != mesi_q;
  assign ta_wr_index = ta_wr_en ? idx : '0;
  assign ta_wr_way = ta_wr_en ? way_q : '0;
  assign ta_wr_mesi = ta_wr_en ? nxt : MESI_I;
  assign l1_msg_valid = state_q == GETL1 || (rsp_valid && msg != L1_NONE);
  assign l1_msg = state_q == GETL1 ? L1_GETLINE : rsp_valid ? msg : L1_NONE;
  assign l1_msg_addr = l1_msg_valid ? addr_q : '0;
  assign wb_valid = state_q == WB;
  assign wb_addr = wb_valid ? line : '0;
endmodule
